// File: rtl/text_console_writer.sv
// ============================================================================
// Module   : text_console_writer
// Brief    : Byte-stream console front end driving the text/attr RAM write port
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module text_console_writer #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 25,
    parameter int          ADDR_W       = 11,
    parameter logic [7:0]  CLEAR_CHAR   = 8'h20,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F,
    localparam int         COL_W        = $clog2(COLS),
    localparam int         ROW_W        = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              sys_resetn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic [7:0]        in_attr,
    output logic              in_ready,
    input  logic              cmd_clear,
    output logic              busy,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata_text,
    output logic [7:0]        wdata_attr,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        CLR_LINE = 2'd1,
        IDLE     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        text_q, text_d;
    logic [7:0]        attr_q, attr_d;

    logic [ADDR_W-1:0] cur_addr;
    logic              do_newline;
    logic              do_clear;

    assign in_ready   = (state_q == IDLE) & ~cmd_clear;
    assign busy       = (state_q != IDLE);
    assign wen        = wen_q;
    assign waddr      = waddr_q;
    assign wdata_text = text_q;
    assign wdata_attr = attr_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign cur_addr   = row_base_q + ADDR_W'(col_q);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        cnt_d      = cnt_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        text_d     = text_q;
        attr_d     = attr_q;
        do_newline = 1'b0;
        do_clear   = cmd_clear;

        if (!cmd_clear) begin
            case (state_q)
                CLR_ALL: begin
                    wen_d   = 1'b1;
                    waddr_d = cnt_q;
                    text_d  = CLEAR_CHAR;
                    attr_d  = DEFAULT_ATTR;
                    if (cnt_q == SCR_LAST) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                CLR_LINE: begin
                    wen_d   = 1'b1;
                    waddr_d = row_base_q + cnt_q;
                    text_d  = CLEAR_CHAR;
                    attr_d  = DEFAULT_ATTR;
                    if (cnt_q == LINE_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        if (in_data >= 8'h20) begin
                            wen_d   = 1'b1;
                            waddr_d = cur_addr;
                            text_d  = in_data;
                            attr_d  = in_attr;
                            if (col_q == LAST_COL) begin
                                do_newline = 1'b1;
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end else begin
                            case (in_data)
                                8'h0D: col_d = '0;
                                8'h0A: do_newline = 1'b1;
                                8'h08: begin
                                    // Backspace erases the cell it steps back onto
                                    if (col_q != '0) begin
                                        col_d   = col_q - COL_W'(1);
                                        wen_d   = 1'b1;
                                        waddr_d = cur_addr - ADDR_W'(1);
                                        text_d  = CLEAR_CHAR;
                                        attr_d  = in_attr;
                                    end
                                end
                                8'h0C:   do_clear = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                default: do_clear = 1'b1;
            endcase
        end

        if (do_newline) begin
            col_d      = '0;
            row_d      = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            row_base_d = (row_q == LAST_ROW) ? '0 : row_base_q + ADDR_W'(COLS);
            cnt_d      = '0;
            state_d    = CLR_LINE;
        end

        if (do_clear) begin
            state_d    = CLR_ALL;
            cnt_d      = '0;
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
        end
    end

    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q    <= CLR_ALL;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            text_q     <= '0;
            attr_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            text_q     <= text_d;
            attr_q     <= attr_d;
        end
    end

endmodule

`default_nettype wire
